// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM controller: FSM state encoding, the
// width of the access wait counter, and default bus widths.
package sram_ctrl_pkg;

  localparam int CNT_W      = 3;
  localparam int DEF_ADDR_W = 18;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/sram_if_buf.sv
// One-entry fetch buffer for sram_ctrl (built only when SRAM_CTRL_IF_BUF_EN
// is defined in the top).
// Ports:
//   clk, rst           clock, async active-low reset (entry invalid)
//   lookup_addr_i      fetch address to compare against the entry
//   hit_o, data_o      entry valid and address match; buffered data
//   fill_i/_addr/_data refill the entry after an SRAM fetch
//   inv_i, inv_addr_i  data-port write address; drops a matching entry
module sram_if_buf
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int IF_ADDR_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IF_ADDR_W-1:0] lookup_addr_i,
  output logic                 hit_o,
  output logic [DATA_W-1:0]    data_o,
  input  logic                 fill_i,
  input  logic [IF_ADDR_W-1:0] fill_addr_i,
  input  logic [DATA_W-1:0]    fill_data_i,
  input  logic                 inv_i,
  input  logic [ADDR_W-1:0]    inv_addr_i
);

  logic                 valid_q;
  logic [IF_ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0]    data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (fill_i) begin
      valid_q <= 1'b1;
      addr_q  <= fill_addr_i;
      data_q  <= fill_data_i;
    end else if (inv_i && valid_q && (inv_addr_i == ADDR_W'(addr_q))) begin
      // fetch addresses live in the zero-extended low part of SRAM space
      valid_q <= 1'b0;
    end
  end

  assign hit_o  = valid_q && (lookup_addr_i == addr_q);
  assign data_o = data_q;

endmodule

// File: rtl/sram_ctrl.sv
// Asynchronous SRAM controller with a read/write data port and a read-only
// fetch port. Data port has priority. Each access: IDLE -> ACCESS for
// WAIT_CYC+1 cycles -> DONE (ack, write hold) -> IDLE. All strobes registered.
// Optional: define SRAM_CTRL_IF_BUF_EN for a one-entry fetch buffer
// (sram_if_buf); a buffered fetch skips the SRAM and acks after one cycle.
// Ports:
//   clk, rst                    clock, async active-low reset
//   mem_req_i/we_i/addr_i/wdata_i, mem_ack_o, mem_rdata_o   data port
//   if_req_i/addr_i, if_ack_o, if_rdata_o                  fetch port
//   sram_addr_o, sram_data_io, sram_en_n_o/oe_n_o/we_n_o   SRAM pins
//   busy_o                      state is not IDLE
//
// state  | meaning
// IDLE   | waiting for a request; data port wins over fetch
// ACCESS | strobes active, WAIT_CYC+1 cycles; read sampled on the last edge
// DONE   | one-cycle ack; write data still driven with we_n released
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int IF_ADDR_W = 16,
  parameter int WAIT_CYC  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_req_i,
  input  logic                 mem_we_i,
  input  logic [ADDR_W-1:0]    mem_addr_i,
  input  logic [DATA_W-1:0]    mem_wdata_i,
  output logic                 mem_ack_o,
  output logic [DATA_W-1:0]    mem_rdata_o,
  input  logic                 if_req_i,
  input  logic [IF_ADDR_W-1:0] if_addr_i,
  output logic                 if_ack_o,
  output logic [DATA_W-1:0]    if_rdata_o,
  output logic [ADDR_W-1:0]    sram_addr_o,
  inout  wire  [DATA_W-1:0]    sram_data_io,
  output logic                 sram_en_n_o,
  output logic                 sram_oe_n_o,
  output logic                 sram_we_n_o,
  output logic                 busy_o
);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               we_q;
  logic               src_if_q;
  logic               drv_q;
  logic               en_n_q, oe_n_q, we_n_q;
  logic               mem_ack_q, if_ack_q;
  logic [DATA_W-1:0]  mem_rdata_q, if_rdata_q;

  logic               buf_hit;
  logic [DATA_W-1:0]  buf_data;
  logic               last_access;

  assign last_access = (state_q == ACCESS) && (cnt_q == '0);

`ifdef SRAM_CTRL_IF_BUF_EN
  logic fill_en, inv_en;

  assign fill_en = last_access && src_if_q;
  assign inv_en  = (state_q == IDLE) && mem_req_i && mem_we_i;

  sram_if_buf #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .IF_ADDR_W (IF_ADDR_W)
  ) u_if_buf (
    .clk           (clk),
    .rst           (rst),
    .lookup_addr_i (if_addr_i),
    .hit_o         (buf_hit),
    .data_o        (buf_data),
    .fill_i        (fill_en),
    .fill_addr_i   (addr_q[IF_ADDR_W-1:0]),
    .fill_data_i   (sram_data_io),
    .inv_i         (inv_en),
    .inv_addr_i    (mem_addr_i)
  );
`else
  assign buf_hit  = 1'b0;
  assign buf_data = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      src_if_q    <= 1'b0;
      drv_q       <= 1'b0;
      en_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      mem_ack_q   <= 1'b0;
      if_ack_q    <= 1'b0;
      mem_rdata_q <= '0;
      if_rdata_q  <= '0;
    end else begin
      mem_ack_q <= 1'b0;
      if_ack_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mem_req_i) begin
            state_q  <= ACCESS;
            cnt_q    <= CNT_W'(WAIT_CYC);
            addr_q   <= mem_addr_i;
            wdata_q  <= mem_wdata_i;
            we_q     <= mem_we_i;
            src_if_q <= 1'b0;
            drv_q    <= mem_we_i;
            en_n_q   <= 1'b0;
            oe_n_q   <= mem_we_i;
            we_n_q   <= ~mem_we_i;
          end else if (if_req_i) begin
            src_if_q <= 1'b1;
            we_q     <= 1'b0;
            if (buf_hit) begin
              // buffered fetch: no SRAM cycle, ack straight from DONE
              state_q    <= DONE;
              if_ack_q   <= 1'b1;
              if_rdata_q <= buf_data;
            end else begin
              state_q <= ACCESS;
              cnt_q   <= CNT_W'(WAIT_CYC);
              addr_q  <= ADDR_W'(if_addr_i);
              en_n_q  <= 1'b0;
              oe_n_q  <= 1'b0;
              we_n_q  <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            state_q <= DONE;
            en_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            if (src_if_q) begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= sram_data_io;
            end else begin
              mem_ack_q <= 1'b1;
              if (!we_q) mem_rdata_q <= sram_data_io;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          drv_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sram_data_io = drv_q ? wdata_q : {DATA_W{1'bz}};
  assign sram_addr_o  = addr_q;
  assign sram_en_n_o  = en_n_q;
  assign sram_oe_n_o  = oe_n_q;
  assign sram_we_n_o  = we_n_q;
  assign mem_ack_o    = mem_ack_q;
  assign mem_rdata_o  = mem_rdata_q;
  assign if_ack_o     = if_ack_q;
  assign if_rdata_o   = if_rdata_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_sram_ctrl.sv
module tb_sram_ctrl;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  // instance A: WAIT_CYC=1, instance B: WAIT_CYC=0
  logic        a_mem_req, a_mem_we, a_if_req;
  logic [17:0] a_mem_addr;
  logic [15:0] a_mem_wdata, a_if_addr;
  logic        a_mem_ack, a_if_ack, a_en_n, a_oe_n, a_we_n, a_busy;
  logic [15:0] a_mem_rdata, a_if_rdata;
  logic [17:0] a_sram_addr;
  wire  [15:0] bus_a;

  logic        b_mem_req, b_mem_we, b_if_req;
  logic [17:0] b_mem_addr;
  logic [15:0] b_mem_wdata, b_if_addr;
  logic        b_mem_ack, b_if_ack, b_en_n, b_oe_n, b_we_n, b_busy;
  logic [15:0] b_mem_rdata, b_if_rdata;
  logic [17:0] b_sram_addr;
  wire  [15:0] bus_b;

  sram_ctrl #(.ADDR_W(18), .DATA_W(16), .IF_ADDR_W(16), .WAIT_CYC(1)) u_dut_a (
    .clk(clk), .rst(rst_n),
    .mem_req_i(a_mem_req), .mem_we_i(a_mem_we), .mem_addr_i(a_mem_addr),
    .mem_wdata_i(a_mem_wdata), .mem_ack_o(a_mem_ack), .mem_rdata_o(a_mem_rdata),
    .if_req_i(a_if_req), .if_addr_i(a_if_addr), .if_ack_o(a_if_ack),
    .if_rdata_o(a_if_rdata), .sram_addr_o(a_sram_addr), .sram_data_io(bus_a),
    .sram_en_n_o(a_en_n), .sram_oe_n_o(a_oe_n), .sram_we_n_o(a_we_n),
    .busy_o(a_busy)
  );

  sram_ctrl #(.ADDR_W(18), .DATA_W(16), .IF_ADDR_W(16), .WAIT_CYC(0)) u_dut_b (
    .clk(clk), .rst(rst_n),
    .mem_req_i(b_mem_req), .mem_we_i(b_mem_we), .mem_addr_i(b_mem_addr),
    .mem_wdata_i(b_mem_wdata), .mem_ack_o(b_mem_ack), .mem_rdata_o(b_mem_rdata),
    .if_req_i(b_if_req), .if_addr_i(b_if_addr), .if_ack_o(b_if_ack),
    .if_rdata_o(b_if_rdata), .sram_addr_o(b_sram_addr), .sram_data_io(bus_b),
    .sram_en_n_o(b_en_n), .sram_oe_n_o(b_oe_n), .sram_we_n_o(b_we_n),
    .busy_o(b_busy)
  );

  // simple asynchronous SRAM models (1K words, low address bits)
  logic [15:0] mem_a [0:1023];
  logic [15:0] mem_b [0:1023];
  assign bus_a = (!a_en_n && !a_oe_n) ? mem_a[a_sram_addr[9:0]] : 16'hzzzz;
  assign bus_b = (!b_en_n && !b_oe_n) ? mem_b[b_sram_addr[9:0]] : 16'hzzzz;
  always @(posedge clk) if (!a_en_n && !a_we_n) mem_a[a_sram_addr[9:0]] <= bus_a;
  always @(posedge clk) if (!b_en_n && !b_we_n) mem_b[b_sram_addr[9:0]] <= bus_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sampled view of the selected instance
  int sel = 0;
  logic        s_en_n, s_oe_n, s_we_n, s_mack, s_iack, s_busy;
  logic [15:0] s_mrd, s_ird, s_bus;
  logic [17:0] s_addr;
  assign s_en_n = sel != 0 ? b_en_n      : a_en_n;
  assign s_oe_n = sel != 0 ? b_oe_n      : a_oe_n;
  assign s_we_n = sel != 0 ? b_we_n      : a_we_n;
  assign s_mack = sel != 0 ? b_mem_ack   : a_mem_ack;
  assign s_iack = sel != 0 ? b_if_ack    : a_if_ack;
  assign s_busy = sel != 0 ? b_busy      : a_busy;
  assign s_mrd  = sel != 0 ? b_mem_rdata : a_mem_rdata;
  assign s_ird  = sel != 0 ? b_if_rdata  : a_if_rdata;
  assign s_bus  = sel != 0 ? bus_b       : bus_a;
  assign s_addr = sel != 0 ? b_sram_addr : a_sram_addr;

  typedef struct {
    int          inst;
    bit          we;
    bit          fetch;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    int          lat;
    int          en;
    int          oe;
    int          wen;
    int          drv;
  } vec_t;

`ifdef SRAM_CTRL_IF_BUF_EN
  localparam int HIT_LAT = 1;
  localparam int HIT_STB = 0;
`else
  localparam int HIT_LAT = 3;
  localparam int HIT_STB = 2;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int inst, input bit mreq, input bit we,
                       input logic [17:0] addr, input logic [15:0] wd,
                       input bit ireq, input logic [15:0] iaddr);
    if (inst == 0) begin
      a_mem_req = mreq; a_mem_we = we; a_mem_addr = addr; a_mem_wdata = wd;
      a_if_req = ireq; a_if_addr = iaddr;
    end else begin
      b_mem_req = mreq; b_mem_we = we; b_mem_addr = addr; b_mem_wdata = wd;
      b_if_req = ireq; b_if_addr = iaddr;
    end
  endtask

  // one transaction; call at a negedge with the selected DUT idle
  task automatic xfer(input vec_t v, input string tag);
    int cyc = 0, en_c = 0, oe_c = 0, we_c = 0, drv_c = 0, oth = 0;
    bit got = 0;
    logic [15:0] rd = '0;
    logic [17:0] ea;
    sel = v.inst;
    ea  = v.fetch ? {2'b00, v.addr[15:0]} : v.addr;
    if (v.fetch) drive(v.inst, 1'b0, 1'b0, '0, '0, 1'b1, v.addr[15:0]);
    else         drive(v.inst, 1'b1, v.we, v.addr, v.wdata, 1'b0, '0);
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (!s_en_n) en_c++;
      if (!s_oe_n) oe_c++;
      if (!s_we_n) we_c++;
      if (v.we && s_bus === v.wdata) drv_c++;
      if (v.fetch ? s_mack : s_iack) oth++;
      if (v.fetch ? s_iack : s_mack) begin
        got = 1;
        rd  = v.fetch ? s_ird : s_mrd;
        drive(v.inst, 1'b0, 1'b0, '0, '0, 1'b0, '0);
      end
    end
    if (!got) drive(v.inst, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    chk({tag, "_lat"},   cyc,   v.lat);
    chk({tag, "_en"},    en_c,  v.en);
    chk({tag, "_oe"},    oe_c,  v.oe);
    chk({tag, "_we"},    we_c,  v.wen);
    chk({tag, "_drv"},   drv_c, v.drv);
    chk({tag, "_other"}, oth,   0);
    if (!v.we) chk({tag, "_rdata"}, rd, v.exp_rd);
    @(negedge clk);
    chk({tag, "_addr"}, s_addr, ea);
    chk({tag, "_busy"}, s_busy, 0);
    if (v.we) chk({tag, "_bus_rel"}, s_bus === v.wdata, 0);
  endtask

  vec_t tbl1 [12];
  vec_t tbl2 [4];

  initial begin
    int mc, ic, both, oe_c, n_ack;
    logic [15:0] r0, r1;

    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, 1'b0, '0);

    //         inst we f  addr       wdata     exp_rd    lat en oe we drv
    tbl1[0]  = '{0, 1, 0, 18'h00012, 16'hBEEF, 16'h0000, 3, 2, 0, 2, 3};
    tbl1[1]  = '{0, 0, 0, 18'h00012, 16'h0000, 16'hBEEF, 3, 2, 2, 0, 0};
    tbl1[2]  = '{0, 1, 0, 18'h00040, 16'hC0DE, 16'h0000, 3, 2, 0, 2, 3};
    tbl1[3]  = '{0, 1, 0, 18'h3FFFF, 16'hA5A5, 16'h0000, 3, 2, 0, 2, 3};
    tbl1[4]  = '{0, 0, 0, 18'h3FFFF, 16'h0000, 16'hA5A5, 3, 2, 2, 0, 0};
    tbl1[5]  = '{0, 1, 0, 18'h0FFFF, 16'h5A5A, 16'h0000, 3, 2, 0, 2, 3};
    tbl1[6]  = '{0, 0, 1, 18'h0FFFF, 16'h0000, 16'h5A5A, 3, 2, 2, 0, 0};
    tbl1[7]  = '{0, 0, 1, 18'h00012, 16'h0000, 16'hBEEF, 3, 2, 2, 0, 0};
    tbl1[8]  = '{1, 1, 0, 18'h00012, 16'hBEEF, 16'h0000, 2, 1, 0, 1, 2};
    tbl1[9]  = '{1, 1, 0, 18'h00040, 16'hC0DE, 16'h0000, 2, 1, 0, 1, 2};
    tbl1[10] = '{1, 1, 0, 18'h00000, 16'h1111, 16'h0000, 2, 1, 0, 1, 2};
    tbl1[11] = '{1, 1, 0, 18'h00001, 16'h2222, 16'h0000, 2, 1, 0, 1, 2};

    tbl2[0]  = '{0, 0, 1, 18'h00040, 16'h0000, 16'hC0DE, 3, 2, 2, 0, 0};
    tbl2[1]  = '{0, 0, 1, 18'h00040, 16'h0000, 16'hC0DE, HIT_LAT, HIT_STB, HIT_STB, 0, 0};
    tbl2[2]  = '{0, 1, 0, 18'h00040, 16'hBEAD, 16'h0000, 3, 2, 0, 2, 3};
    tbl2[3]  = '{0, 0, 1, 18'h00040, 16'h0000, 16'hBEAD, 3, 2, 2, 0, 0};

    repeat (2) @(negedge clk);
    sel = 0;
    chk("rst_en_n",  a_en_n,      1);
    chk("rst_oe_n",  a_oe_n,      1);
    chk("rst_we_n",  a_we_n,      1);
    chk("rst_addr",  a_sram_addr, 0);
    chk("rst_acks",  {a_mem_ack, a_if_ack}, 0);
    chk("rst_rdata", {a_mem_rdata, a_if_rdata}, 0);
    chk("rst_busy",  a_busy,      0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl1[i]) xfer(tbl1[i], $sformatf("t1v%0d", i));
    chk("a_mem_rdata_hold", a_mem_rdata, 16'hA5A5);
    chk("a_if_rdata_hold",  a_if_rdata,  16'hBEEF);

    // reset during a write ACCESS cycle
    sel = 0;
    drive(0, 1'b1, 1'b1, 18'h00050, 16'h7777, 1'b0, '0);
    @(negedge clk);
    chk("mid_we_low", a_we_n, 0);
    chk("mid_busy",   a_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_en_n",  a_en_n, 1);
    chk("ar_oe_n",  a_oe_n, 1);
    chk("ar_we_n",  a_we_n, 1);
    chk("ar_bus",   bus_a === 16'h7777, 0);
    chk("ar_busy",  a_busy, 0);
    chk("ar_addr",  a_sram_addr, 0);
    chk("ar_rdata", {a_mem_rdata, a_if_rdata}, 0);
    drive(0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    n_ack = 0;
    repeat (5) begin
      @(negedge clk);
      if (a_mem_ack || a_if_ack) n_ack++;
    end
    chk("ar_no_ack", n_ack, 0);

    foreach (tbl2[i]) xfer(tbl2[i], $sformatf("t2v%0d", i));

    // simultaneous requests on B: data port first, fetch 3 cycles later
    sel = 1;
    drive(1, 1'b1, 1'b0, 18'h00012, '0, 1'b1, 16'h0040);
    mc = 0; ic = 0; both = 0; r0 = '0; r1 = '0;
    for (int c = 1; c <= 20 && (mc == 0 || ic == 0); c++) begin
      @(negedge clk);
      if (b_mem_ack && b_if_ack) both++;
      if (b_mem_ack) begin mc = c; r0 = b_mem_rdata; b_mem_req = 1'b0; end
      if (b_if_ack)  begin ic = c; r1 = b_if_rdata;  b_if_req  = 1'b0; end
    end
    chk("arb_mem_cyc", mc, 2);
    chk("arb_if_cyc",  ic, 5);
    chk("arb_gap",     ic - mc, 3);
    chk("arb_both",    both, 0);
    chk("arb_mem_rd",  r0, 16'hBEEF);
    chk("arb_if_rd",   r1, 16'hC0DE);
    @(negedge clk);

    // back-to-back fetches on B with if_req held high
    drive(1, 1'b0, 1'b0, '0, '0, 1'b1, 16'h0000);
    mc = 0; ic = 0; oe_c = 0; r0 = '0; r1 = '0;
    for (int c = 1; c <= 20 && ic == 0; c++) begin
      @(negedge clk);
      if (!b_oe_n) oe_c++;
      if (b_if_ack) begin
        if (mc == 0) begin
          mc = c; r0 = b_if_rdata; b_if_addr = 16'h0001;
        end else begin
          ic = c; r1 = b_if_rdata; b_if_req = 1'b0;
        end
      end
    end
    b_if_req = 1'b0;
    chk("b2b_first", mc, 2);
    chk("b2b_gap",   ic - mc, 3);
    chk("b2b_oe",    oe_c, 2);
    chk("b2b_rd0",   r0, 16'h1111);
    chk("b2b_rd1",   r1, 16'h2222);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
